// File: rtl/clk_monitor.sv
// Period/lock monitor for a divided clock sampled in the reference clk domain.
// Reports each period in clk cycles, declares lock and flags loss of clock.
module clk_monitor #(
    parameter int REFERENCE_CLOCK = 16_000_000,
    parameter int FREQUENCY       = 153_846,
    parameter int TOLERANCE       = 2,
    parameter int LOCK_COUNT      = 4,
    parameter int NBITS           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [NBITS-1:0] period_count,
    output logic             count_valid,
    output logic             freq_ok,
    output logic             timeout
);

    localparam int EXPECTED = REFERENCE_CLOCK / FREQUENCY;
    localparam int TIMEOUT  = 2 * EXPECTED;
    localparam int LO_I     = (EXPECTED > TOLERANCE) ? EXPECTED - TOLERANCE : 0;

    localparam logic [NBITS-1:0] LO   = NBITS'(LO_I);
    localparam logic [NBITS-1:0] HI   = NBITS'(EXPECTED + TOLERANCE);
    localparam logic [NBITS-1:0] TO   = NBITS'(TIMEOUT);
    localparam logic [3:0]       LOCK = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state_q, state_d;
    logic             s1, s2, s3;
    logic             sig_rise;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       good_q, good_d;
    logic             in_tol;

    assign sig_rise = s2 & ~s3;
    assign in_tol   = (cnt_q >= LO) && (cnt_q <= HI);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        good_d    = good_q;
        if (!enable) begin
            // disable overrides any coincident edge: no report
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
            good_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    good_d    = '0;
                end
                ARM: begin
                    if (sig_rise) begin
                        cnt_d   = NBITS'(1);
                        state_d = MEASURE;
                    end else if (cnt_q == TO) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (sig_rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        cnt_d     = NBITS'(1);
                        timeout_d = 1'b0;
                        if (in_tol)
                            good_d = (good_q == LOCK) ? LOCK : good_q + 4'd1;
                        else
                            good_d = '0;
                    end else if (cnt_q == TO) begin
                        timeout_d = 1'b1;
                        good_d    = '0;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            good_q    <= '0;
        end else begin
            state_q   <= state_d;
            s1        <= sig_in;
            s2        <= s1;
            s3        <= s2;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            good_q    <= good_d;
        end
    end

    assign period_count = period_q;
    assign count_valid  = valid_q;
    assign timeout      = timeout_q;
    assign freq_ok      = (good_q == LOCK);

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor: expected reports queued per rising edge,
// compared when count_valid pulses.
module tb_clk_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sig_in;
    logic [31:0] period_count;
    logic        count_valid;
    logic        freq_ok;
    logic        timeout;

    clk_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sig_in      (sig_in),
        .period_count(period_count),
        .count_valid (count_valid),
        .freq_ok     (freq_ok),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   period;
        logic ok;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    logic armed = 1'b0;
    int   last_p = 0;
    int   good_m = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp,
                     $time);
        end
    endtask

    // lock model: 102..106 is in tolerance, lock after 4 good periods
    task automatic note_rise(input int p);
        exp_t e;
        if (armed) begin
            if (last_p >= 102 && last_p <= 106)
                good_m = (good_m < 4) ? good_m + 1 : 4;
            else
                good_m = 0;
            e.period = last_p;
            e.ok     = (good_m == 4);
            q.push_back(e);
        end
        last_p = p;
        armed  = 1'b1;
    endtask

    task automatic pulse(input int p);
        @(negedge clk);
        sig_in = 1'b1;
        note_rise(p);
        repeat (p / 2) @(negedge clk);
        sig_in = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
    endtask

    task automatic pulses(input int p, input int n);
        for (int i = 0; i < n; i++) pulse(p);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (count_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("period", period_count, e.period);
                    check("freq_ok", {31'd0, freq_ok}, {31'd0, e.ok});
                    check("timeout_clr", {31'd0, timeout}, 32'd0);
                end
            end
        end
    end

    initial begin : stim
        int k;
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", period_count, 32'd0);
        check("rst_valid", {31'd0, count_valid}, 32'd0);
        check("rst_freq_ok", {31'd0, freq_ok}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        pulses(104, 6);
        check("nom_locked", {31'd0, freq_ok}, 32'd1);
        check("nom_no_timeout", {31'd0, timeout}, 32'd0);

        pulses(110, 6);
        check("slow_unlocked", {31'd0, freq_ok}, 32'd0);
        pulses(105, 6);

        pulses(104, 5);
        pulses(107, 1);
        pulses(104, 5);
        check("relock_107", {31'd0, freq_ok}, 32'd1);

        // loss of clock: one last rise then sig_in held low
        @(negedge clk);
        sig_in = 1'b1;
        note_rise(104);
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (k == 52) sig_in = 1'b0;
            if (timeout) break;
        end
        check("timeout_latency", k, 211);
        check("timeout_freq_ok", {31'd0, freq_ok}, 32'd0);
        check("timeout_hold", period_count, 32'd104);
        armed  = 1'b0;
        good_m = 0;
        pulse(104);
        check("timeout_sticky", {31'd0, timeout}, 32'd1);
        pulses(104, 6);
        check("relock_timeout", {31'd0, freq_ok}, 32'd1);

        // one-cycle reset mid-period while locked
        @(negedge clk);
        sig_in = 1'b1;
        note_rise(104);
        repeat (52) @(negedge clk);
        sig_in = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_period", period_count, 32'd0);
        check("mid_rst_valid", {31'd0, count_valid}, 32'd0);
        check("mid_rst_freq_ok", {31'd0, freq_ok}, 32'd0);
        check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        armed  = 1'b0;
        good_m = 0;
        repeat (30) @(negedge clk);
        pulses(104, 6);
        check("relock_reset", {31'd0, freq_ok}, 32'd1);

        // enable dropped for 10 cycles while locked
        @(negedge clk);
        sig_in = 1'b1;
        note_rise(104);
        repeat (52) @(negedge clk);
        sig_in = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("dis_freq_ok", {31'd0, freq_ok}, 32'd0);
        check("dis_hold", period_count, 32'd104);
        check("dis_valid", {31'd0, count_valid}, 32'd0);
        enable = 1'b1;
        armed  = 1'b0;
        good_m = 0;
        repeat (21) @(negedge clk);
        pulses(104, 4);
        check("dis_not_yet", {31'd0, freq_ok}, 32'd0);
        pulses(104, 2);
        check("relock_enable", {31'd0, freq_ok}, 32'd1);

        repeat (10) @(negedge clk);
        check("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
